sdram_arbit: RTL
================

SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 Parameter TIMEOUT, default 1023: maximum cycles a grant may stay open without its end pulse.
REQ-002 Parameter NOP_CMD, default 4'b0111: command driven when no requester owns the bus.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-004 sysclk_100M  in  1  system clock; all logic on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 init_end  in  1  level; power-up init sequence complete.
REQ-007 init_cmd/init_addr/init_bank  in  4/13/2  init module bus.
REQ-008 ref_req  in  1  level; refresh due.
REQ-009 ref_end  in  1  pulse; refresh sequence done.
REQ-010 ref_cmd/ref_addr  in  4/13  refresh module bus.
REQ-011 wr_req, rd_req  in  1 each  level; held until acked.
REQ-012 wr_end, rd_end  in  1 each  pulse; burst and precharge done.
REQ-013 wr_cmd/wr_addr/wr_bank, rd_cmd/rd_addr/rd_bank  in  4/13/2 each  write and read module buses.
REQ-014 ref_ack, wr_ack, rd_ack  out  1 each  one-cycle grant pulse.
REQ-015 refresh_pending  out  1  registered copy of ref_req, forwarded to write and read modules for early termination.
REQ-016 sdram_cmd/sdram_addr/sdram_bank  out  4/13/2  registered SDRAM bus.
REQ-017 timeout_err  out  1  one-cycle pulse on grant timeout.

Function
REQ-018 FSM states: S_INIT, S_ARBIT, S_REF, S_WRITE, S_READ; one-hot encoding.
REQ-019 S_INIT -> S_ARBIT when init_end=1; otherwise stay.
REQ-020 S_ARBIT priority: ref_req -> S_REF; else the granted one of wr_req/rd_req per REQ-021 -> S_WRITE or S_READ; else stay.
REQ-021 Write/read fairness: 1-bit last_served flag, reset to READ; with both wr_req and rd_req high and no ref_req, grant the type not last served; a lone request is granted regardless; flag updates on each write or read grant.
REQ-022 The matching ack is high for exactly the cycle the FSM first occupies the grant state; never more than one ack high.
REQ-023 S_REF/S_WRITE/S_READ -> S_ARBIT on ref_end/wr_end/rd_end respectively; end pulses of non-owners ignored.
REQ-024 At least one S_ARBIT cycle between consecutive grants; a request present in the end-pulse cycle is served no earlier than the following arbitration.
REQ-025 Bus mux selected by state: S_INIT init bus; S_REF ref_cmd/ref_addr with bank 2'b00; S_WRITE write bus; S_READ read bus; S_ARBIT NOP_CMD, addr 0, bank 0.
REQ-026 sdram_* registered: value at cycle n+1 reflects owner's inputs and state at cycle n (1-cycle latency, uniform across owners).
REQ-027 Grant counter, 10 bits, cleared on entry to a grant state, increments each grant-state cycle; reaching TIMEOUT forces S_ARBIT, pulses timeout_err, and drives NOP next cycle.
REQ-028 refresh_pending = ref_req delayed one cycle, in all states.
REQ-029 ref_req rising while S_WRITE/S_READ active does not preempt; ownership ends only on the owner's end pulse or timeout.

Reset
REQ-030 With rst=1 at a clock edge: state S_INIT, acks 0, timeout_err 0, refresh_pending 0, sdram_cmd NOP_CMD, sdram_addr 0, sdram_bank 0, last_served READ, grant counter 0.
REQ-031 Reset asserted mid-grant aborts immediately to S_INIT with the values above; S_ARBIT is re-entered only after init_end.

Verification
REQ-032 Reset, init_end=0 for 50 cycles, init_cmd=4'b0010 -> sdram_cmd follows init_cmd one cycle later; no ack; init_end=1 -> S_ARBIT, sdram_cmd=4'b0111.
REQ-033 ref_req, wr_req, rd_req all rise the same cycle in S_ARBIT -> ref_ack next cycle only; after ref_end, wr_ack (last_served=READ); after wr_end, rd_ack.
REQ-034 wr_req held high continuously, rd_req single request -> grant order write, read, write; ≥1 NOP cycle between each grant.
REQ-035 Write granted, wr_cmd=4'b0100, wr_addr=13'h0A5, wr_bank=2'b01 -> same values on sdram_* one cycle later; rd_cmd changes ignored.
REQ-036 Read granted, rd_end never pulsed -> timeout_err pulse after TIMEOUT=1023 grant cycles, sdram_cmd=4'b0111 next cycle, new request granted thereafter.
REQ-037 rst pulsed during S_READ -> next cycle sdram_cmd=4'b0111, all acks 0, rd_req ignored until init_end.

Source files
------------

// File: rtl/sdram_arbit.sv
// Bus arbiter for one SDRAM: init owns the bus until init_end, then refresh,
// write and read modules take turns with refresh first and write/read alternating.
module sdram_arbit #(
  parameter int         TIMEOUT = 1023,
  parameter logic [3:0] NOP_CMD = 4'b0111
) (
  input  logic        sysclk_100M,
  input  logic        rst,
  input  logic        init_end,
  input  logic [3:0]  init_cmd,
  input  logic [12:0] init_addr,
  input  logic [1:0]  init_bank,
  input  logic        ref_req,
  input  logic        ref_end,
  input  logic [3:0]  ref_cmd,
  input  logic [12:0] ref_addr,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [12:0] wr_addr,
  input  logic [1:0]  wr_bank,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [12:0] rd_addr,
  input  logic [1:0]  rd_bank,
  output logic        ref_ack,
  output logic        wr_ack,
  output logic        rd_ack,
  output logic        refresh_pending,
  output logic [3:0]  sdram_cmd,
  output logic [12:0] sdram_addr,
  output logic [1:0]  sdram_bank,
  output logic        timeout_err,
  output logic [4:0]  state_dbg
);

  // Handshake: *_req is a level held by the requester until its ack; *_ack is a
  // one-cycle pulse in the first cycle of ownership; the owner keeps the bus
  // until it pulses its *_end (or the grant times out), then arbitration resumes.
  typedef enum logic [4:0] {
    S_INIT  = 5'b00001,
    S_ARBIT = 5'b00010,
    S_REF   = 5'b00100,
    S_WRITE = 5'b01000,
    S_READ  = 5'b10000
  } state_t;

  localparam logic       LS_READ  = 1'b0;
  localparam logic       LS_WRITE = 1'b1;
  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

  state_t      state, next_state;
  logic        last_served;
  logic [9:0]  grant_cnt;
  logic        grant_state, timed_out, pick_write;
  logic        ref_ack_d, wr_ack_d, rd_ack_d;
  logic [3:0]  cmd_d;
  logic [12:0] addr_d;
  logic [1:0]  bank_d;

  assign grant_state = (state == S_REF) || (state == S_WRITE) || (state == S_READ);
  // grant_cnt is 0 in the first grant cycle, so CNT_LAST marks the TIMEOUT-th cycle
  assign timed_out   = grant_state && (grant_cnt == CNT_LAST);
  assign pick_write  = wr_req && (!rd_req || (last_served == LS_READ));
  assign state_dbg   = state;

  always_ff @(posedge sysclk_100M) begin
    if (rst) state <= S_INIT;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_INIT:  if (init_end) next_state = S_ARBIT;
      S_ARBIT: begin
        if (ref_req)         next_state = S_REF;
        else if (pick_write) next_state = S_WRITE;
        else if (rd_req)     next_state = S_READ;
      end
      S_REF:   if (ref_end || timed_out) next_state = S_ARBIT;
      S_WRITE: if (wr_end || timed_out)  next_state = S_ARBIT;
      S_READ:  if (rd_end || timed_out)  next_state = S_ARBIT;
      default: next_state = S_INIT;
    endcase
  end

  always_comb begin
    ref_ack_d = (state == S_ARBIT) && (next_state == S_REF);
    wr_ack_d  = (state == S_ARBIT) && (next_state == S_WRITE);
    rd_ack_d  = (state == S_ARBIT) && (next_state == S_READ);
    cmd_d     = NOP_CMD;
    addr_d    = '0;
    bank_d    = '0;
    case (state)
      S_INIT:  begin cmd_d = init_cmd; addr_d = init_addr; bank_d = init_bank; end
      S_REF:   begin cmd_d = ref_cmd;  addr_d = ref_addr;  bank_d = 2'b00;     end
      S_WRITE: begin cmd_d = wr_cmd;   addr_d = wr_addr;   bank_d = wr_bank;   end
      S_READ:  begin cmd_d = rd_cmd;   addr_d = rd_addr;   bank_d = rd_bank;   end
      default: ;
    endcase
  end

  always_ff @(posedge sysclk_100M) begin
    if (rst) begin
      ref_ack         <= 1'b0;
      wr_ack          <= 1'b0;
      rd_ack          <= 1'b0;
      timeout_err     <= 1'b0;
      refresh_pending <= 1'b0;
      sdram_cmd       <= NOP_CMD;
      sdram_addr      <= '0;
      sdram_bank      <= '0;
      last_served     <= LS_READ;
      grant_cnt       <= '0;
    end else begin
      ref_ack         <= ref_ack_d;
      wr_ack          <= wr_ack_d;
      rd_ack          <= rd_ack_d;
      timeout_err     <= timed_out;
      refresh_pending <= ref_req;
      sdram_cmd       <= cmd_d;
      sdram_addr      <= addr_d;
      sdram_bank      <= bank_d;
      if (wr_ack_d)      last_served <= LS_WRITE;
      else if (rd_ack_d) last_served <= LS_READ;
      if (!grant_state)  grant_cnt <= '0;
      else               grant_cnt <= grant_cnt + 10'd1;
    end
  end

endmodule
